// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the port arbiter and a single-ported memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_stall;

  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        dm_stall;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data accesses: data has priority,
// but a waiting fetch is forced through after STARVE_LIMIT consecutive data completions.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             owner;
  logic             owner_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             pick_fetch;
  logic             pick_data;

  logic             cmd_we;
  logic [3:0]       cmd_be;
  logic [31:0]      cmd_addr;
  logic [31:0]      cmd_wdata;
  logic [31:0]      if_rdata_q;
  logic [31:0]      dm_rdata_q;

  always_comb begin
    starved    = (starve_cnt == CNT_MAX);
    pick_fetch = bus.if_req && (!bus.dm_req || starved);
    pick_data  = bus.dm_req && !pick_fetch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Owner is only re-chosen in IDLE, so it stays valid through REQ/WAIT/DONE
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    unique case (state)
      IDLE: begin
        if (pick_fetch || pick_data) begin
          state_nxt = REQ;
          owner_nxt = pick_data;
        end
      end
      REQ:  if (bus.mem_gnt)    state_nxt = WAIT;
      WAIT: if (bus.mem_rvalid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_we    <= 1'b0;
      cmd_be    <= 4'h0;
      cmd_addr  <= 32'h0;
      cmd_wdata <= 32'h0;
    end else if (state == IDLE) begin
      if (pick_data) begin
        cmd_we    <= bus.dm_we;
        cmd_be    <= bus.dm_be;
        cmd_addr  <= bus.dm_addr;
        cmd_wdata <= bus.dm_wdata;
      end else if (pick_fetch) begin
        cmd_we    <= 1'b0;
        cmd_be    <= 4'hF;
        cmd_addr  <= bus.if_addr;
        cmd_wdata <= 32'h0;
      end
    end
  end

  // Write completions leave dm_rdata untouched; rvalid outside WAIT is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= 32'h0;
      dm_rdata_q <= 32'h0;
    end else if (state == WAIT && bus.mem_rvalid) begin
      if (!owner)       if_rdata_q <= bus.mem_rdata;
      else if (!cmd_we) dm_rdata_q <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == DONE) begin
      if (!owner)
        starve_cnt <= '0;
      else if (bus.if_req && !starved)
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    bus.mem_req   = (state == REQ);
    bus.mem_we    = cmd_we;
    bus.mem_be    = cmd_be;
    bus.mem_addr  = cmd_addr;
    bus.mem_wdata = cmd_wdata;
    bus.if_ack    = (state == DONE) && !owner;
    bus.dm_ack    = (state == DONE) && owner;
    bus.if_rdata  = if_rdata_q;
    bus.dm_rdata  = dm_rdata_q;
  end

  assign bus.if_stall = bus.if_req && !bus.if_ack;
  assign bus.dm_stall = bus.dm_req && !bus.dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing sequences, a transaction table, and a
// randomized run against a priority/starvation reference model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  localparam int LIMIT = 4;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] rd;
    int          gdel;
    logic        fetch;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_if_rdata;
    logic [31:0] e_dm_rdata;
  } vec_t;

  vec_t tbl [7];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = 4'h0;
    bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_mem_req(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_req === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: mem_req timeout got 0 expected 1 within 20 cycles", name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        e;
    bit          ok;
    bit          exp_d;
    int          starve_m;
    logic [31:0] exp_if_rd, exp_dm_rd, rv_data;
    logic [31:0] ex_addr, ex_wdata;
    logic        ex_we, exp_owner, in_flight, mreq_prev, ack_due, ack_this, data_wins;
    logic [3:0]  ex_be;
    bit          mem_wait;
    int          quiet;

    tbl[0] = '{1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h55555555, 32'h11112222, 0,
               1'b0, 32'h2000, 1'b0, 4'hF, 32'h55555555, 32'h00500093, 32'h11112222};
    tbl[1] = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hA5A5A5A5, 0,
               1'b1, 32'h100, 1'b0, 4'hF, 32'h0, 32'hA5A5A5A5, 32'h11112222};
    tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h3000, 32'hDEADBEEF, 32'h0BADF00D, 3,
               1'b0, 32'h3000, 1'b1, 4'b0011, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h11112222};
    tbl[3] = '{1'b1, 32'h200, 1'b1, 1'b1, 4'hC, 32'h3004, 32'hCAFEF00D, 32'h12345678, 1,
               1'b0, 32'h3004, 1'b1, 4'hC, 32'hCAFEF00D, 32'hA5A5A5A5, 32'h11112222};
    tbl[4] = '{1'b1, 32'h200, 1'b1, 1'b0, 4'h1, 32'hFFFFFFFC, 32'h0, 32'h000000FF, 0,
               1'b0, 32'hFFFFFFFC, 1'b0, 4'h1, 32'h0, 32'hA5A5A5A5, 32'h000000FF};
    tbl[5] = '{1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h13579BDF, 2,
               1'b1, 32'h200, 1'b0, 4'hF, 32'h0, 32'h13579BDF, 32'h000000FF};
    tbl[6] = '{1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 0,
               1'b1, 32'hFFFFFFFC, 1'b0, 4'hF, 32'h0, 32'h0, 32'h000000FF};

    // Reset values
    do_reset();
    chk1 ("rst_mem_req",   bus.mem_req,   1'b0);
    chk1 ("rst_mem_we",    bus.mem_we,    1'b0);
    chk32("rst_mem_be",    {28'h0, bus.mem_be}, 32'h0);
    chk32("rst_mem_addr",  bus.mem_addr,  32'h0);
    chk32("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk1 ("rst_if_ack",    bus.if_ack,    1'b0);
    chk1 ("rst_dm_ack",    bus.dm_ack,    1'b0);
    chk32("rst_if_rdata",  bus.if_rdata,  32'h0);
    chk32("rst_dm_rdata",  bus.dm_rdata,  32'h0);

    // Fetch-only minimum-latency transaction
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    chk1("fo_c1_mem_req", bus.mem_req, 1'b0);
    tick();
    chk1 ("fo_c2_mem_req", bus.mem_req, 1'b1);
    chk32("fo_c2_addr", bus.mem_addr, 32'h100);
    chk1 ("fo_c2_we", bus.mem_we, 1'b0);
    chk32("fo_c2_be", {28'h0, bus.mem_be}, 32'hF);
    bus.mem_gnt = 1'b1; bus.mem_rdata = 32'h00500093;
    tick();
    bus.mem_gnt = 1'b0;
    chk1("fo_c3_mem_req", bus.mem_req, 1'b0);
    bus.mem_rvalid = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    chk1 ("fo_c4_if_ack", bus.if_ack, 1'b1);
    chk1 ("fo_c4_dm_ack", bus.dm_ack, 1'b0);
    chk32("fo_c4_if_rdata", bus.if_rdata, 32'h00500093);
    chk1 ("fo_c4_if_stall", bus.if_stall, 1'b0);
    bus.if_req = 1'b0;
    tick();
    chk1("fo_c5_if_ack", bus.if_ack, 1'b0);

    // Transaction table
    for (int v = 0; v < 7; v++) begin
      e = tbl[v];
      bus.if_req = e.if_req; bus.if_addr = e.if_addr;
      bus.dm_req = e.dm_req; bus.dm_we = e.dm_we; bus.dm_be = e.dm_be;
      bus.dm_addr = e.dm_addr; bus.dm_wdata = e.dm_wdata;
      wait_mem_req($sformatf("tbl%0d", v), ok);
      if (ok) begin
        chk32($sformatf("tbl%0d_addr", v), bus.mem_addr, e.e_addr);
        chk1 ($sformatf("tbl%0d_we", v), bus.mem_we, e.e_we);
        chk32($sformatf("tbl%0d_be", v), {28'h0, bus.mem_be}, {28'h0, e.e_be});
        chk32($sformatf("tbl%0d_wdata", v), bus.mem_wdata, e.e_wdata);
        for (int k = 0; k < e.gdel; k++) begin
          tick();
          chk1 ($sformatf("tbl%0d_req_hold%0d", v, k), bus.mem_req, 1'b1);
          chk32($sformatf("tbl%0d_addr_hold%0d", v, k), bus.mem_addr, e.e_addr);
          chk32($sformatf("tbl%0d_wdata_hold%0d", v, k), bus.mem_wdata, e.e_wdata);
          chk32($sformatf("tbl%0d_bewe_hold%0d", v, k), {27'h0, bus.mem_we, bus.mem_be},
                {27'h0, e.e_we, e.e_be});
        end
        // rvalid alongside gnt must be ignored
        bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
        tick();
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = e.rd;
        tick();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h5A5A5A5A;
        chk1 ($sformatf("tbl%0d_if_ack", v), bus.if_ack, e.fetch);
        chk1 ($sformatf("tbl%0d_dm_ack", v), bus.dm_ack, !e.fetch);
        chk32($sformatf("tbl%0d_if_rdata", v), bus.if_rdata, e.e_if_rdata);
        chk32($sformatf("tbl%0d_dm_rdata", v), bus.dm_rdata, e.e_dm_rdata);
        chk1 ($sformatf("tbl%0d_if_stall", v), bus.if_stall, e.if_req && !e.fetch);
        chk1 ($sformatf("tbl%0d_dm_stall", v), bus.dm_stall, e.dm_req && e.fetch);
        if (e.fetch) bus.if_req = 1'b0; else bus.dm_req = 1'b0;
        tick();
        chk32($sformatf("tbl%0d_ack_pulse", v), {30'h0, bus.if_ack, bus.dm_ack}, 32'h0);
      end
    end

    // Starvation: both requests held, expect four data completions then one fetch
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h400;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF; bus.dm_addr = 32'h4000;
    for (int n = 0; n < 10; n++) begin
      exp_d = (n % 5) != 4;
      wait_mem_req($sformatf("starve%0d", n), ok);
      if (!ok) break;
      chk32($sformatf("starve%0d_addr", n), bus.mem_addr, exp_d ? 32'h4000 : 32'h400);
      bus.mem_gnt = 1'b1;
      tick();
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'(n);
      tick();
      bus.mem_rvalid = 1'b0;
      chk1($sformatf("starve%0d_dm_ack", n), bus.dm_ack, exp_d);
      chk1($sformatf("starve%0d_if_ack", n), bus.if_ack, !exp_d);
      chk1($sformatf("starve%0d_if_stall", n), bus.if_stall, exp_d);
      tick();
    end

    // Reset while waiting for the response
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    wait_mem_req("rstwait", ok);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    rst_n = 1'b0;
    #2;
    chk1 ("rstwait_async_req", bus.mem_req, 1'b0);
    chk32("rstwait_async_addr", bus.mem_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    bus.if_req = 1'b0;
    tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77777777;
    tick();
    bus.mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk32($sformatf("rstwait_noack%0d", k), {30'h0, bus.if_ack, bus.dm_ack}, 32'h0);
      chk1 ($sformatf("rstwait_req%0d", k), bus.mem_req, 1'b0);
      chk32($sformatf("rstwait_if_rdata%0d", k), bus.if_rdata, 32'h0);
      tick();
    end
    bus.if_req = 1'b1; bus.if_addr = 32'h600;
    tick();
    chk1 ("rstwait_fresh_req", bus.mem_req, 1'b1);
    chk32("rstwait_fresh_addr", bus.mem_addr, 32'h600);

    // Randomized traffic against the reference model
    do_reset();
    starve_m = 0; exp_if_rd = 32'h0; exp_dm_rd = 32'h0; rv_data = 32'h0;
    ex_addr = 32'h0; ex_wdata = 32'h0; ex_we = 1'b0; ex_be = 4'h0;
    exp_owner = 1'b0; in_flight = 1'b0; mreq_prev = 1'b0; ack_due = 1'b0;
    mem_wait = 1'b0; quiet = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk1("rnd_if_stall", bus.if_stall, bus.if_req && !bus.if_ack);
      chk1("rnd_dm_stall", bus.dm_stall, bus.dm_req && !bus.dm_ack);
      chk1("rnd_if_ack", bus.if_ack, ack_due && !exp_owner);
      chk1("rnd_dm_ack", bus.dm_ack, ack_due && exp_owner);
      ack_this = ack_due;
      ack_due  = 1'b0;
      if (ack_this) begin
        in_flight = 1'b0;
        quiet = 0;
        if (!exp_owner) exp_if_rd = rv_data;
        else if (!ex_we) exp_dm_rd = rv_data;
        if (!exp_owner) begin
          bus.if_req  = 1'($urandom_range(0, 1));
          bus.if_addr = $urandom;
        end else begin
          bus.dm_req   = 1'($urandom_range(0, 1));
          bus.dm_we    = 1'($urandom_range(0, 1));
          bus.dm_be    = 4'($urandom_range(0, 15));
          bus.dm_addr  = $urandom;
          bus.dm_wdata = $urandom;
        end
      end
      chk32("rnd_if_rdata", bus.if_rdata, exp_if_rd);
      chk32("rnd_dm_rdata", bus.dm_rdata, exp_dm_rd);

      if (bus.mem_req && !mreq_prev) begin
        data_wins = bus.dm_req && !(bus.if_req && starve_m == LIMIT);
        chk1("rnd_spurious_grant", in_flight || !(bus.if_req || bus.dm_req), 1'b0);
        exp_owner = data_wins;
        in_flight = 1'b1;
        if (data_wins) begin
          ex_addr = bus.dm_addr; ex_we = bus.dm_we; ex_be = bus.dm_be; ex_wdata = bus.dm_wdata;
        end else begin
          ex_addr = bus.if_addr; ex_we = 1'b0; ex_be = 4'hF; ex_wdata = 32'h0;
        end
      end
      if (bus.mem_req) begin
        chk32("rnd_mem_addr", bus.mem_addr, ex_addr);
        chk32("rnd_mem_ctl", {27'h0, bus.mem_we, bus.mem_be}, {27'h0, ex_we, ex_be});
        if (ex_we) chk32("rnd_mem_wdata", bus.mem_wdata, ex_wdata);
      end

      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
      if (bus.mem_req) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.mem_gnt = 1'b1;
          mem_wait = 1'b1;
        end
        bus.mem_rvalid = ($urandom_range(0, 3) == 0);
      end else if (mem_wait) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.mem_rvalid = 1'b1;
          rv_data = bus.mem_rdata;
          mem_wait = 1'b0;
          ack_due = 1'b1;
        end
      end else begin
        bus.mem_rvalid = ($urandom_range(0, 4) == 0);
      end

      if (!bus.if_req && $urandom_range(0, 3) == 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = $urandom;
      end
      if (!bus.dm_req && $urandom_range(0, 3) == 0) begin
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'($urandom_range(0, 1));
        bus.dm_be    = 4'($urandom_range(0, 15));
        bus.dm_addr  = $urandom;
        bus.dm_wdata = $urandom;
      end

      if (ack_this) begin
        if (!exp_owner) starve_m = 0;
        else if (bus.if_req && starve_m < LIMIT) starve_m = starve_m + 1;
      end

      if (bus.if_req || bus.dm_req || in_flight) quiet++;
      if (quiet > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL rnd_progress: no completion for %0d cycles, expected within 100", quiet);
        break;
      end
      mreq_prev = bus.mem_req;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT SHALL be: STARVE_LIMIT, default 4, max consecutive data grants while a fetch waits.
REQ-002 Port clk SHALL be: clk  input  1  sole clock, rising edge.
REQ-003 Port rst_n SHALL be: rst_n  input  1  asynchronous active-low reset.
REQ-004 Fetch ports SHALL be: if_req input 1 fetch request; if_addr input 32 fetch address; if_rdata output 32 fetched word; if_ack output 1 fetch-complete pulse; if_stall output 1 hold IF stage.
REQ-005 Data ports SHALL be: dm_req input 1 load/store request; dm_we input 1 write enable; dm_be input 4 byte enables; dm_addr input 32; dm_wdata input 32; dm_rdata output 32; dm_ack output 1 completion pulse; dm_stall output 1 hold MEM stage.
REQ-006 Memory ports SHALL be: mem_req output 1; mem_we output 1; mem_be output 4; mem_addr output 32; mem_wdata output 32; mem_gnt input 1 request accepted; mem_rvalid input 1 response valid; mem_rdata input 32.

Function
REQ-007 The block SHALL implement FSM states IDLE, REQ, WAIT, DONE and a 1-bit owner register (0=fetch, 1=data).
REQ-008 In IDLE, with any request pending, the block SHALL arbitrate, latch the winner's command (addr, we, be, wdata; fetch uses we=0, be=4'hF), and move to REQ next cycle; with no request, it SHALL stay in IDLE.
REQ-009 Arbitration SHALL grant data over fetch, except fetch wins when if_req=1 and starve counter == STARVE_LIMIT.
REQ-010 In REQ, mem_req SHALL be 1 and mem_* fields SHALL be driven from the latched command, stable until mem_gnt=1; on mem_gnt the FSM SHALL move to WAIT.
REQ-011 In WAIT, mem_req SHALL be 0; on mem_rvalid the block SHALL capture mem_rdata into the owner's rdata register and move to DONE. mem_rvalid outside WAIT SHALL be ignored.
REQ-012 In DONE, the owner's ack SHALL be 1 for exactly that cycle, no arbitration SHALL occur, and the FSM SHALL return to IDLE.
REQ-013 Writes SHALL complete through the same mem_rvalid handshake; dm_rdata SHALL remain unchanged on a write completion.
REQ-014 if_rdata and dm_rdata SHALL hold their last captured value until overwritten by the next completion for that owner.
REQ-015 if_stall SHALL equal if_req AND NOT if_ack; dm_stall SHALL equal dm_req AND NOT dm_ack (combinational).
REQ-016 Starve counter (width clog2(STARVE_LIMIT+1)) SHALL increment, saturating at STARVE_LIMIT, on each data completion (DONE, owner=1) while if_req=1; it SHALL clear on each fetch completion.
REQ-017 Requesters SHALL hold req and fields stable until ack; changes to an unselected or in-flight request SHALL NOT affect the latched command.
REQ-018 Back-to-back: a request still asserted after its ack cycle SHALL be treated as a new request at the next IDLE cycle; minimum turnaround is 4 cycles (IDLE, REQ, WAIT, DONE) with mem_gnt and mem_rvalid each on first opportunity.
REQ-019 The memory side SHALL assert mem_rvalid no earlier than one cycle after mem_gnt; mem_gnt and mem_rvalid in the same cycle SHALL accept gnt only.

Reset
REQ-020 On rst_n=0, asynchronously: FSM=IDLE, owner=0, starve counter=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0.
REQ-021 Reset asserted mid-transaction (REQ or WAIT) SHALL abandon it with no ack; a later stale mem_rvalid SHALL be ignored in IDLE.

Verification
REQ-022 Fetch only: if_req=1, if_addr=0x100, gnt and rvalid immediate, mem_rdata=0x00500093 -> mem_req in cycle 2, if_ack=1 in cycle 4, if_rdata=0x00500093, if_stall=0 that cycle.
REQ-023 Simultaneous: if_req=1, dm_req=1 (load 0x2000) in same IDLE cycle -> data served first (mem_addr=0x2000, mem_we=0), if_stall stays 1 until fetch completes afterwards.
REQ-024 Starvation: STARVE_LIMIT=4, dm_req held high continuously, if_req=1 -> exactly 4 data completions, then fetch granted; counter then 0.
REQ-025 Store: dm_we=1, dm_be=4'b0011, dm_wdata=0xDEADBEEF, mem_gnt delayed 3 cycles -> mem_* stable for all 4 REQ cycles, dm_ack one pulse, dm_rdata unchanged.
REQ-026 Reset in WAIT: drop rst_n after mem_gnt, release, then pulse mem_rvalid -> no ack, mem_req=0, FSM IDLE.
